layer_out_array: RTL and testbench

//  Parametrised successor to the single-channel layer output: drives CH_NUM WS2812 strings in

---
 rtl/layer_out_pkg.sv | 25 ++
 rtl/layer_buf.sv | 41 ++++
 rtl/layer_out_array.sv | 166 ++++++++++++++++
 tb/tb_layer_out_array.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_out_pkg.sv
// Shared types and constants for the multi-channel WS2812 layer output.
//   state_e  : frame sequencer states
//   pixel_t  : one GRB pixel, G in the MSB so it is shifted out first
//   BE_*     : bit positions of the G/R/B byte enables in the write strobe
package layer_out_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BIT,
    RST
  } state_e;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  localparam int PIX_W = 24;
  localparam int BE_G  = 2;
  localparam int BE_R  = 1;
  localparam int BE_B  = 0;

endpackage

// File: rtl/layer_buf.sv
// Per-channel double-buffered frame store: two banks of LED_NUM GRB pixels.
// Ports:
//   clk        : clock, rising edge
//   wr_en      : write strobe (already qualified for this channel/address)
//   wr_bank    : bank written
//   wr_addr    : LED index written
//   wr_byte_en : [2]=G [1]=R [0]=B; disabled bytes keep their old value
//   wr_data    : pixel to write
//   rd_bank    : bank read
//   rd_addr    : LED index read
//   rd_data    : registered read data, valid one cycle after the address
module layer_buf
  import layer_out_pkg::*;
#(
  parameter  int LED_NUM = 64,
  localparam int AW      = $clog2(LED_NUM)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_byte_en,
  input  pixel_t        wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output pixel_t        rd_data
);

  // Bank select is the address MSB; depth rounds up to a power of two.
  logic [PIX_W-1:0] mem [2**(AW+1)];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_byte_en[BE_G]) mem[{wr_bank, wr_addr}][23:16] <= wr_data.g;
      if (wr_byte_en[BE_R]) mem[{wr_bank, wr_addr}][15:8]  <= wr_data.r;
      if (wr_byte_en[BE_B]) mem[{wr_bank, wr_addr}][7:0]   <= wr_data.b;
    end
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/layer_out_array.sv
// Drives CH_NUM WS2812 strings in lock-step from one shared bit-timing engine.
// Each channel has a double-buffered frame store; a frame request swaps banks
// and streams every channel in parallel, MSB first (G7..B0).
// Ports:
//   clk_in          : clock, rising edge
//   rst_in          : synchronous active-high reset
//   wr_en_in        : pixel write strobe (always targets the back bank)
//   wr_chan_in      : target channel; out-of-range writes are dropped
//   wr_addr_in      : target LED; out-of-range writes are dropped
//   wr_byte_en_in   : [2]=G [1]=R [0]=B byte enables
//   wr_data_in      : {G,R,B} pixel
//   layer_en_in     : per-channel enable, latched at frame start
//   frame_rdy_in    : frame request pulse; queued (one deep) while busy
//   busy_out        : high from frame start until frame_done_out
//   frame_done_out  : one-cycle pulse after the latch time
//   ws2812_data_out : serial data per string
module layer_out_array
  import layer_out_pkg::*;
#(
  parameter  int CH_NUM   = 8,
  parameter  int LED_NUM  = 64,
  parameter  int T0H_CYC  = 20,
  parameter  int T1H_CYC  = 40,
  parameter  int TBIT_CYC = 63,
  parameter  int TRST_CYC = 15000,
  localparam int CW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int AW       = $clog2(LED_NUM)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              wr_en_in,
  input  logic [CW-1:0]     wr_chan_in,
  input  logic [AW-1:0]     wr_addr_in,
  input  logic [2:0]        wr_byte_en_in,
  input  logic [23:0]       wr_data_in,
  input  logic [CH_NUM-1:0] layer_en_in,
  input  logic              frame_rdy_in,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic [CH_NUM-1:0] ws2812_data_out
);

  localparam int CYW = $clog2(TBIT_CYC);
  localparam int RW  = (TRST_CYC > 1) ? $clog2(TRST_CYC) : 1;

  state_e            state;
  logic              front;
  logic              pending;
  logic              ld_phase;
  logic [CH_NUM-1:0] en_lat;
  logic [CH_NUM-1:0] bit_level;
  logic [AW-1:0]     led_idx;
  logic [AW-1:0]     rd_addr;
  logic [4:0]        bit_idx;
  logic [CYW-1:0]    cyc;
  logic [RW-1:0]     rst_cnt;
  logic              addr_ok;
  pixel_t            rd_p0 [CH_NUM];
  logic [PIX_W-1:0]  sh_p1 [CH_NUM];

  assign addr_ok = ({1'b0, wr_addr_in} < (AW+1)'(LED_NUM));

  // While a LED is being shifted out, the read port already fetches the next
  // one so the following LED can load without a gap between bit periods.
  always_comb begin
    rd_addr = led_idx;
    if (state == BIT) rd_addr = led_idx + AW'(1);
  end

  // Stage p0: registered frame-store read, one per channel
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en_in && (wr_chan_in == CW'(c)) && addr_ok;

    layer_buf #(.LED_NUM(LED_NUM)) u_buf (
      .clk        (clk_in),
      .wr_en      (ch_wr),
      .wr_bank    (!front),
      .wr_addr    (wr_addr_in),
      .wr_byte_en (wr_byte_en_in),
      .wr_data    (wr_data_in),
      .rd_bank    (front),
      .rd_addr    (rd_addr),
      .rd_data    (rd_p0[c])
    );
  end

  // Stage p1: shift registers + shared cycle counter -> line level
  always_comb begin
    bit_level = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      bit_level[c] = en_lat[c] &&
                     (cyc < (sh_p1[c][PIX_W-1] ? CYW'(T1H_CYC) : CYW'(T0H_CYC)));
    end
  end

  // Stage p2: registered pin outputs and frame sequencer
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      front           <= 1'b0;
      pending         <= 1'b0;
      ld_phase        <= 1'b0;
      busy_out        <= 1'b0;
      frame_done_out  <= 1'b0;
      ws2812_data_out <= '0;
    end else begin
      frame_done_out  <= 1'b0;
      ws2812_data_out <= '0;
      if (state != IDLE && frame_rdy_in) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_rdy_in || pending) begin
            front    <= !front;
            en_lat   <= layer_en_in;
            pending  <= 1'b0;
            led_idx  <= '0;
            ld_phase <= 1'b0;
            busy_out <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          // First cycle presents the address, second cycle has the data.
          ld_phase <= 1'b1;
          if (ld_phase) begin
            for (int c = 0; c < CH_NUM; c++) sh_p1[c] <= rd_p0[c];
            bit_idx <= 5'd23;
            cyc     <= '0;
            state   <= BIT;
          end
        end
        BIT: begin
          ws2812_data_out <= bit_level;
          if (cyc == CYW'(TBIT_CYC - 1)) begin
            cyc <= '0;
            if (bit_idx != 5'd0) begin
              bit_idx <= bit_idx - 5'd1;
              for (int c = 0; c < CH_NUM; c++) sh_p1[c] <= {sh_p1[c][PIX_W-2:0], 1'b0};
            end else if (led_idx == AW'(LED_NUM - 1)) begin
              rst_cnt <= '0;
              state   <= RST;
            end else begin
              led_idx <= led_idx + AW'(1);
              bit_idx <= 5'd23;
              for (int c = 0; c < CH_NUM; c++) sh_p1[c] <= rd_p0[c];
            end
          end else begin
            cyc <= cyc + CYW'(1);
          end
        end
        RST: begin
          if (rst_cnt == RW'(TRST_CYC - 1)) begin
            frame_done_out <= 1'b1;
            busy_out       <= 1'b0;
            state          <= IDLE;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_out_array.sv
module tb_layer_out_array;

  localparam int CH   = 3;
  localparam int LED  = 3;
  localparam int T0H  = 3;
  localparam int T1H  = 6;
  localparam int TBIT = 9;
  localparam int TRST = 30;
  localparam int CW   = 2;
  localparam int AW   = 2;
  localparam int WV   = 24 * TBIT;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [CW-1:0] wr_chan;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_be;
  logic [23:0]   wr_data;
  logic [CH-1:0] layer_en;
  logic          frame_rdy;
  logic          busy;
  logic          done;
  logic [CH-1:0] ws;

  always #5 clk = ~clk;

  layer_out_array #(
    .CH_NUM(CH), .LED_NUM(LED), .T0H_CYC(T0H), .T1H_CYC(T1H),
    .TBIT_CYC(TBIT), .TRST_CYC(TRST)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .wr_en_in        (wr_en),
    .wr_chan_in      (wr_chan),
    .wr_addr_in      (wr_addr),
    .wr_byte_en_in   (wr_be),
    .wr_data_in      (wr_data),
    .layer_en_in     (layer_en),
    .frame_rdy_in    (frame_rdy),
    .busy_out        (busy),
    .frame_done_out  (done),
    .ws2812_data_out (ws)
  );

  // Reference model: both banks of every channel, which bank is displayed,
  // and whether a queued frame request is outstanding.
  logic [23:0]   mem_m [2][CH][LED];
  int            front_m;
  logic [CH-1:0] en_m;
  bit            pending_m;
  int            frame_no;

  // Mid-frame stimulus knobs, consumed by frame_body.
  int            mid_wr_k;
  int            mid_ch;
  int            mid_a;
  logic [23:0]   mid_d;
  int            rdy_ks[$];

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int ch, input int a, input logic [2:0] be, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_chan = CW'(ch);
    wr_addr = AW'(a);
    wr_be   = be;
    wr_data = d;
    if (ch < CH && a < LED) begin
      if (be[2]) mem_m[1-front_m][ch][a][23:16] = d[23:16];
      if (be[1]) mem_m[1-front_m][ch][a][15:8]  = d[15:8];
      if (be[0]) mem_m[1-front_m][ch][a][7:0]   = d[7:0];
    end
  endtask

  task automatic wr_pix(input int ch, input int a, input logic [2:0] be, input logic [23:0] d);
    drive_wr(ch, a, be, d);
    tick();
    wr_en = 1'b0;
  endtask

  // Called just after the edge on which the DUT accepted a frame.
  task automatic frame_body();
    logic [WV-1:0] obs [CH];
    logic [WV-1:0] expv;
    logic [23:0]   pix;
    bit            bad;
    int            k;
    front_m   = 1 - front_m;
    en_m      = layer_en;
    pending_m = 0;
    frame_no++;
    check($sformatf("busy_start_f%0d", frame_no), busy, 1);
    bad = 0;
    tick(); if (ws !== '0) bad = 1;
    tick(); if (ws !== '0) bad = 1;
    check($sformatf("pre_rise_low_f%0d", frame_no), bad, 0);
    k   = 0;
    bad = 0;
    for (int l = 0; l < LED; l++) begin
      for (int j = WV - 1; j >= 0; j--) begin
        tick();
        for (int c = 0; c < CH; c++) obs[c][j] = ws[c];
        if (busy !== 1'b1 || done !== 1'b0) bad = 1;
        wr_en     = 1'b0;
        frame_rdy = 1'b0;
        if (k == mid_wr_k) drive_wr(mid_ch, mid_a, 3'b111, mid_d);
        foreach (rdy_ks[i]) if (k == rdy_ks[i]) begin
          frame_rdy = 1'b1;
          pending_m = 1;
        end
        k++;
      end
      for (int c = 0; c < CH; c++) begin
        pix  = mem_m[front_m][c][l];
        expv = '0;
        if (en_m[c]) begin
          for (int b = 0; b < 24; b++)
            for (int t = 0; t < TBIT; t++)
              expv[WV-1-(b*TBIT+t)] = (t < (pix[23-b] ? T1H : T0H));
        end
        check($sformatf("wave_f%0d_c%0d_l%0d", frame_no, c, l), obs[c], expv);
      end
    end
    check($sformatf("busy_in_bits_f%0d", frame_no), bad, 0);
    bad = 0;
    for (int i = 0; i < TRST - 1; i++) begin
      tick();
      wr_en     = 1'b0;
      frame_rdy = 1'b0;
      if (ws !== '0 || done !== 1'b0 || busy !== 1'b1) bad = 1;
    end
    check($sformatf("latch_low_f%0d", frame_no), bad, 0);
    tick();
    check($sformatf("frame_done_f%0d", frame_no), done, 1);
    check($sformatf("busy_end_f%0d", frame_no), busy, 0);
  endtask

  task automatic clear_knobs();
    mid_wr_k = -1;
    rdy_ks.delete();
  endtask

  task automatic start_frame(input bit co_wr, input int ch, input int a, input logic [23:0] d);
    frame_rdy = 1'b1;
    if (co_wr) drive_wr(ch, a, 3'b111, d);
    tick();
    frame_rdy = 1'b0;
    wr_en     = 1'b0;
    frame_body();
  endtask

  // Runs any queued frame, then confirms the DUT goes and stays idle.
  task automatic finish_frames();
    bit bad;
    clear_knobs();
    while (pending_m) begin
      tick();
      frame_body();
    end
    bad = 0;
    repeat (15) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) bad = 1;
    end
    check($sformatf("idle_after_f%0d", frame_no), bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    n_chk = 0; n_pass = 0;
    front_m = 0; pending_m = 0; frame_no = 0;
    rst = 1'b1; wr_en = 1'b0; wr_chan = '0; wr_addr = '0; wr_be = '0; wr_data = '0;
    layer_en = '1; frame_rdy = 1'b0;
    clear_knobs();
    repeat (3) tick();
    check("rst_ws", ws, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Fill back bank, then known patterns, byte enables and dropped writes.
    for (int c = 0; c < CH; c++)
      for (int l = 0; l < LED; l++) wr_pix(c, l, 3'b111, 24'($urandom()));
    wr_pix(1, 0, 3'b111, 24'hFF0000);
    wr_pix(1, 1, 3'b111, 24'h000001);
    wr_pix(0, 0, 3'b111, 24'h112233);
    wr_pix(0, 0, 3'b010, 24'hAABBCC);
    wr_pix(3, 0, 3'b111, 24'($urandom()));
    wr_pix(0, 3, 3'b111, 24'($urandom()));
    layer_en = '1;
    start_frame(0, 0, 0, 24'h0);
    finish_frames();

    // Other bank: ch1 white but disabled, write coincident with the request,
    // and a mid-frame write that must not show until the next frame.
    for (int c = 0; c < CH; c++)
      for (int l = 0; l < LED; l++) wr_pix(c, l, 3'b111, 24'($urandom()));
    for (int l = 0; l < LED; l++) wr_pix(1, l, 3'b111, 24'hFFFFFF);
    layer_en = 3'b101;
    mid_wr_k = 100; mid_ch = 0; mid_a = 0; mid_d = 24'h123456;
    start_frame(1, 2, 2, 24'($urandom()));
    finish_frames();

    // Three requests while busy collapse into exactly one extra frame.
    layer_en = '1;
    rdy_ks.push_back(50);
    rdy_ks.push_back(300);
    rdy_ks.push_back(600);
    start_frame(0, 0, 0, 24'h0);
    finish_frames();

    // Reset during bit 5 of LED1, with a request already queued.
    frame_rdy = 1'b1;
    tick();
    frame_rdy = 1'b0;
    repeat (10) tick();
    frame_rdy = 1'b1;
    tick();
    frame_rdy = 1'b0;
    repeat (254) tick();
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    tick();
    check("midrst_ws", ws, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    front_m = 0; pending_m = 0;
    bad = 0;
    repeat (LED * WV + TRST + 20) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || ws !== '0) bad = 1;
    end
    check("quiet_after_rst", bad, 0);

    // Fresh frame after reset with random enables.
    layer_en = CH'($urandom_range(1, 7));
    start_frame(0, 0, 0, 24'h0);
    finish_frames();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
